// File: rtl/mips_cpu_bus_pkg.sv
// mips_cpu_bus_pkg: shared types and constants for the CPU bus arbiter
package mips_cpu_bus_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DATA = 2'd2, DONE = 2'd3} arb_state_t;
    typedef enum logic {PORT_FETCH, PORT_DATA} port_t;
    localparam logic [3:0] BE_WORD = 4'b1111;
endpackage

// File: rtl/mips_cpu_bus_arbiter.sv
// mips_cpu_bus_arbiter: shares one Avalon master between fetch and load/store ports
//   fetch_* : fetch requester (req/addr in, ack/rdata out)
//   data_*  : load/store requester (req/write/addr/wdata/byteenable in, ack/rdata out)
//   address/read/write/writedata/byteenable/waitrequest/readdata : Avalon master
//   busy    : registered, high whenever the FSM is not in IDLE
module mips_cpu_bus_arbiter
    import mips_cpu_bus_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ack,
    output logic [31:0] fetch_rdata,
    input  logic        data_req,
    input  logic        data_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_byteenable,
    output logic        data_ack,
    output logic [31:0] data_rdata,
    output logic        busy,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);
    arb_state_t state;
    port_t      last_grant;
    port_t      pick;
    // On contention round-robin flips away from the last winner; fixed mode favours data.
    always_comb
        pick = (fetch_req && data_req)
             ? ((ROUND_ROBIN != 0 && last_grant == PORT_DATA) ? PORT_FETCH : PORT_DATA)
             : (data_req ? PORT_DATA : PORT_FETCH);
    // Bus outputs are registers with async reset, so read/write drop the instant rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= PORT_FETCH;
            address     <= '0;
            read        <= 1'b0;
            write       <= 1'b0;
            writedata   <= '0;
            byteenable  <= '0;
            fetch_ack   <= 1'b0;
            fetch_rdata <= '0;
            data_ack    <= 1'b0;
            data_rdata  <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_req || data_req) begin
                        last_grant <= pick;
                        busy       <= 1'b1;
                        address    <= (pick == PORT_DATA) ? data_addr : fetch_addr;
                        if (pick == PORT_DATA) begin
                            writedata  <= data_wdata;
                            byteenable <= data_byteenable;
                            read       <= !data_write;
                            write      <= data_write;
                            state      <= DATA;
                        end else begin
                            byteenable <= BE_WORD;
                            read       <= 1'b1;
                            write      <= 1'b0;
                            state      <= FETCH;
                        end
                    end
                end
                FETCH, DATA: begin
                    if (!waitrequest) begin
                        if (state == FETCH) begin
                            fetch_rdata <= readdata;
                            fetch_ack   <= 1'b1;
                        end else begin
                            if (read)
                                data_rdata <= readdata;
                            data_ack <= 1'b1;
                        end
                        read       <= 1'b0;
                        write      <= 1'b0;
                        byteenable <= '0;
                        state      <= DONE;
                    end
                end
                default: begin
                    fetch_ack <= 1'b0;
                    data_ack  <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// tb_mips_cpu_bus_arbiter: directed self-checking bench for the bus arbiter
module tb_mips_cpu_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        data_req = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [3:0]  data_byteenable = '0;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata = '0;
    logic        fetch_ack, data_ack, busy, read, write;
    logic [31:0] fetch_rdata, data_rdata, address, writedata;
    logic [3:0]  byteenable;
    logic        fetch_ack_0, data_ack_0, busy_0, read_0, write_0;
    logic [31:0] fetch_rdata_0, data_rdata_0, address_0, writedata_0;
    logic [3:0]  byteenable_0;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_cpu_bus_arbiter #(.ROUND_ROBIN(1)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
        .data_req(data_req), .data_write(data_write), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_byteenable(data_byteenable), .data_ack(data_ack), .data_rdata(data_rdata), .busy(busy),
        .address(address), .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
        .waitrequest(waitrequest), .readdata(readdata)
    );

    mips_cpu_bus_arbiter #(.ROUND_ROBIN(0)) dut0 (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack_0), .fetch_rdata(fetch_rdata_0),
        .data_req(data_req), .data_write(data_write), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_byteenable(data_byteenable), .data_ack(data_ack_0), .data_rdata(data_rdata_0), .busy(busy_0),
        .address(address_0), .read(read_0), .write(write_0), .writedata(writedata_0), .byteenable(byteenable_0),
        .waitrequest(waitrequest), .readdata(readdata)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if ({address, read, write, writedata, byteenable, fetch_ack, fetch_rdata, data_ack, data_rdata, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got addr=%h rd=%b wr=%b wd=%h be=%b fa=%b fr=%h da=%b dr=%h busy=%b, want all zero",
                     address, read, write, writedata, byteenable, fetch_ack, fetch_rdata, data_ack, data_rdata, busy);
        end
        n_cmp++;
        if ({address_0, read_0, write_0, writedata_0, byteenable_0, fetch_ack_0, fetch_rdata_0, data_ack_0, data_rdata_0, busy_0} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs_fixed: got addr=%h rd=%b wr=%b busy=%b, want all zero", address_0, read_0, write_0, busy_0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        @(negedge clk);
        fetch_addr = 32'hBFC00000;
        fetch_req = 1'b1;
        readdata = 32'h24020005;
        waitrequest = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({address, read, write, byteenable, busy} !== {32'hBFC00000, 1'b1, 1'b0, 4'hF, 1'b1}) begin
            n_err++;
            $display("FAIL fetch_cmd: got addr=%h rd=%b wr=%b be=%b busy=%b, want BFC00000 1 0 1111 1", address, read, write, byteenable, busy);
        end
        @(negedge clk);
        n_cmp++;
        if ({fetch_ack, fetch_rdata, data_ack, read, byteenable} !== {1'b1, 32'h24020005, 1'b0, 1'b0, 4'h0}) begin
            n_err++;
            $display("FAIL fetch_ack: got fa=%b fr=%h da=%b rd=%b be=%b, want 1 24020005 0 0 0000", fetch_ack, fetch_rdata, data_ack, read, byteenable);
        end
        fetch_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, fetch_ack, address} !== {1'b0, 1'b0, 32'hBFC00000}) begin
            n_err++;
            $display("FAIL fetch_idle: got busy=%b fa=%b addr=%h, want 0 0 BFC00000", busy, fetch_ack, address);
        end
    endtask

    task automatic test_store_wait();
        @(negedge clk);
        data_req = 1'b1;
        data_write = 1'b1;
        data_addr = 32'h1000;
        data_wdata = 32'hDEADBEEF;
        data_byteenable = 4'b0011;
        waitrequest = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({address, writedata, byteenable, write, read, data_ack} !== {32'h1000, 32'hDEADBEEF, 4'b0011, 1'b1, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL store_hold[%0d]: got addr=%h wd=%h be=%b wr=%b rd=%b da=%b, want 00001000 DEADBEEF 0011 1 0 0",
                         i, address, writedata, byteenable, write, read, data_ack);
            end
            if (i == 1) begin
                data_addr = 32'h2000;
                data_wdata = 32'h0;
            end
            if (i == 3) waitrequest = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if ({data_ack, fetch_ack, write, read, data_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL store_ack: got da=%b fa=%b wr=%b rd=%b dr=%h, want 1 0 0 0 00000000", data_ack, fetch_ack, write, read, data_rdata);
        end
        data_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, data_ack} !== 2'b00) begin
            n_err++;
            $display("FAIL store_idle: got busy=%b da=%b, want 0 0", busy, data_ack);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_data;
        exp_data = 4'b0101;
        do_reset();
        fetch_addr = 32'h100;
        data_addr = 32'h200;
        data_write = 1'b0;
        readdata = 32'hCAFE0001;
        waitrequest = 1'b0;
        fetch_req = 1'b1;
        data_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({address, read, write} !== {(exp_data[k] ? 32'h200 : 32'h100), 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL rr_grant[%0d]: got addr=%h rd=%b wr=%b, want %s port", k, address, read, write, exp_data[k] ? "data" : "fetch");
            end
            @(negedge clk);
            n_cmp++;
            if ({fetch_ack, data_ack} !== {!exp_data[k], exp_data[k]}) begin
                n_err++;
                $display("FAIL rr_ack[%0d]: got fa=%b da=%b, want %b %b", k, fetch_ack, data_ack, !exp_data[k], exp_data[k]);
            end
            if (k == 3) begin
                fetch_req = 1'b0;
                data_req = 1'b0;
            end
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0) begin
                n_err++;
                $display("FAIL rr_idle[%0d]: got busy=%b, want 0", k, busy);
            end
        end
        n_cmp++;
        if ({data_rdata, fetch_rdata} !== {32'hCAFE0001, 32'hCAFE0001}) begin
            n_err++;
            $display("FAIL rr_rdata: got dr=%h fr=%h, want CAFE0001 CAFE0001", data_rdata, fetch_rdata);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL rr_quiet: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        fetch_addr = 32'h300;
        data_addr = 32'h400;
        data_write = 1'b0;
        fetch_req = 1'b1;
        data_req = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({address_0, read_0} !== {32'h400, 1'b1}) begin
            n_err++;
            $display("FAIL fixed_first: got addr=%h rd=%b, want 00000400 1", address_0, read_0);
        end
        @(negedge clk);
        n_cmp++;
        if ({data_ack_0, fetch_ack_0} !== 2'b10) begin
            n_err++;
            $display("FAIL fixed_data_ack: got da=%b fa=%b, want 1 0", data_ack_0, fetch_ack_0);
        end
        data_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({address_0, read_0} !== {32'h300, 1'b1}) begin
            n_err++;
            $display("FAIL fixed_second: got addr=%h rd=%b, want 00000300 1", address_0, read_0);
        end
        @(negedge clk);
        n_cmp++;
        if ({fetch_ack_0, data_ack_0} !== 2'b10) begin
            n_err++;
            $display("FAIL fixed_fetch_ack: got fa=%b da=%b, want 1 0", fetch_ack_0, data_ack_0);
        end
        fetch_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_load();
        int acks;
        int t;
        @(negedge clk);
        data_req = 1'b1;
        data_write = 1'b0;
        data_addr = 32'h500;
        waitrequest = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (read !== 1'b1) begin
            n_err++;
            $display("FAIL abort_read_up: got rd=%b, want 1", read);
        end
        #2 rst = 1'b1;
        data_req = 1'b0;
        #1;
        n_cmp++;
        if ({read, write, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL abort_async: got rd=%b wr=%b busy=%b, want 0 0 0", read, write, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        waitrequest = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            acks += int'(data_ack);
        end
        n_cmp++;
        if (acks != 0) begin
            n_err++;
            $display("FAIL abort_no_ack: got %0d data_ack cycles, want 0", acks);
        end
        fetch_addr = 32'h600;
        readdata = 32'h11112222;
        fetch_req = 1'b1;
        t = 0;
        while (fetch_ack !== 1'b1 && t < 6) begin
            @(negedge clk);
            t++;
        end
        fetch_req = 1'b0;
        n_cmp++;
        if ({fetch_ack, fetch_rdata} !== {1'b1, 32'h11112222} || t != 2) begin
            n_err++;
            $display("FAIL abort_refetch: got fa=%b fr=%h after %0d cycles, want 1 11112222 after 2", fetch_ack, fetch_rdata, t);
        end
        @(negedge clk);
    endtask

    task automatic test_boundary();
        @(negedge clk);
        data_req = 1'b1;
        data_write = 1'b1;
        data_addr = 32'h0;
        data_wdata = 32'h12345678;
        data_byteenable = 4'b0000;
        waitrequest = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({address, write, read, byteenable, writedata} !== {32'h0, 1'b1, 1'b0, 4'b0000, 32'h12345678}) begin
            n_err++;
            $display("FAIL be0_store: got addr=%h wr=%b rd=%b be=%b wd=%h, want 0 1 0 0000 12345678", address, write, read, byteenable, writedata);
        end
        @(negedge clk);
        n_cmp++;
        if (data_ack !== 1'b1) begin
            n_err++;
            $display("FAIL be0_ack: got da=%b, want 1", data_ack);
        end
        data_req = 1'b0;
        @(negedge clk);
        fetch_addr = 32'h0;
        readdata = 32'h0000ABCD;
        fetch_req = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({address, read, byteenable} !== {32'h0, 1'b1, 4'hF}) begin
            n_err++;
            $display("FAIL zero_fetch_cmd: got addr=%h rd=%b be=%b, want 0 1 1111", address, read, byteenable);
        end
        @(negedge clk);
        n_cmp++;
        if ({fetch_ack, fetch_rdata} !== {1'b1, 32'h0000ABCD}) begin
            n_err++;
            $display("FAIL zero_fetch_ack: got fa=%b fr=%h, want 1 0000ABCD", fetch_ack, fetch_rdata);
        end
        fetch_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch();
        test_store_wait();
        test_round_robin();
        test_fixed_priority();
        test_reset_mid_load();
        test_boundary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
